ltc_cfg_sequencer: RTL and testbench

LTC_CFG_SEQUENCER -- requirements
Module: ltc_cfg_sequencer

---
 rtl/ltc_cfg_pkg.sv | 40 ++++
 rtl/ltc_spi_frame.sv | 76 +++++++
 rtl/ltc_cfg_sequencer.sv | 127 ++++++++++++
 tb/tb_ltc_cfg_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc_cfg_pkg.sv
// Shared definitions for the LTC ADC configuration sequencer: state encoding,
// frame geometry and the register table programmed after power-up.
package ltc_cfg_pkg;

  localparam int FRAME_W   = 16;
  localparam int TABLE_LEN = 16;

  // IDLE wait | WRITE send entry | GAP_W cs hold | READ read back | GAP_R cs hold
  // CHECK compare | NEXT advance | DONE pass ok | ERROR pass aborted
  typedef enum logic [3:0] {
    IDLE,
    WRITE,
    GAP_W,
    READ,
    GAP_R,
    CHECK,
    NEXT,
    DONE,
    ERROR
  } seq_state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
    logic       verify;
  } cfg_entry_t;

  // Entry 0 is the soft reset; it cannot be read back, so it is never verified.
  localparam cfg_entry_t [0:TABLE_LEN-1] CFG_TABLE = '{
    '{7'h00, 8'h80, 1'b0}, '{7'h01, 8'h00, 1'b1}, '{7'h02, 8'h00, 1'b1}, '{7'h03, 8'h00, 1'b1},
    '{7'h04, 8'h01, 1'b1}, '{7'h05, 8'h00, 1'b1}, '{7'h06, 8'h00, 1'b1}, '{7'h07, 8'h00, 1'b1},
    '{7'h08, 8'h00, 1'b1}, '{7'h09, 8'h00, 1'b1}, '{7'h0a, 8'h00, 1'b1}, '{7'h0b, 8'h00, 1'b1},
    '{7'h0c, 8'h00, 1'b1}, '{7'h0d, 8'h00, 1'b1}, '{7'h0e, 8'h00, 1'b1}, '{7'h0f, 8'h00, 1'b1}
  };

  function automatic logic [FRAME_W-1:0] make_frame(input logic rd, input cfg_entry_t e);
    return {rd, e.addr, (rd ? 8'h00 : e.data)};
  endfunction

endpackage

// File: rtl/ltc_spi_frame.sv
// One SPI mode-0 frame per go pulse: sclk divider, 16-bit shifter and cs timing.
// ack pulses for one cycle after cs returns high; rx_byte holds the last 8 bits sampled.
module ltc_spi_frame
  import ltc_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               go,
  input  logic [FRAME_W-1:0] tx_frame,
  input  logic               sdout,
  output logic               sdin,
  output logic               sclk,
  output logic               cs,
  output logic               ack,
  output logic [7:0]         rx_byte
);

  localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [5:0] SCLK_STEPS = 6'(2 * FRAME_W);
  localparam logic [5:0] END_STEP   = 6'(2 * FRAME_W + 1);

  logic               active;
  logic [7:0]         div_cnt;
  logic [5:0]         step;
  logic [FRAME_W-1:0] tx_shift;
  logic [7:0]         rx_shift;

  assign sdin    = tx_shift[FRAME_W-1];
  assign rx_byte = rx_shift;

  // Every CLK_DIV cycles one step fires: 32 sclk toggles, a trailing low half, then cs release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      step     <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cs       <= 1'b1;
      sclk     <= 1'b0;
      ack      <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!active) begin
        if (go) begin
          active   <= 1'b1;
          cs       <= 1'b0;
          tx_shift <= tx_frame;
          div_cnt  <= DIV_LOAD;
          step     <= '0;
        end
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - 8'd1;
      end else begin
        div_cnt <= DIV_LOAD;
        step    <= step + 6'd1;
        if (step < SCLK_STEPS) begin
          if (!step[0]) begin
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[6:0], sdout};
          end else begin
            sclk     <= 1'b0;
            tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
          end
        end else if (step == END_STEP) begin
          cs     <= 1'b1;
          active <= 1'b0;
          ack    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ltc_cfg_sequencer.sv
// Programs the ADC register table after start, verifying entries by readback
// with a bounded number of re-writes; reports done or the failing address.
module ltc_cfg_sequencer
  import ltc_cfg_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int NUM_REGS  = 5,
  parameter int RETRY_MAX = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       sdout,
  output logic       sdin,
  output logic       sclk,
  output logic       cs,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] err_addr
);

  localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);
  localparam logic [8:0] GAP_LOAD  = 9'(2 * CLK_DIV - 1);

  seq_state_t   state_q, state_d;
  logic [3:0]   index;
  logic [7:0]   retry;
  logic         launched;
  logic [8:0]   gap_cnt;
  logic         go;
  logic         ack;
  logic [7:0]   rx_byte;
  logic         match;
  cfg_entry_t   entry;
  logic [FRAME_W-1:0] tx_frame;

  assign entry    = CFG_TABLE[index];
  assign tx_frame = make_frame(state_q == READ, entry);
  assign match    = (rx_byte == entry.data);
  assign busy     = !(state_q inside {IDLE, DONE, ERROR});

  ltc_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .go       (go),
    .tx_frame (tx_frame),
    .sdout    (sdout),
    .sdin     (sdin),
    .sclk     (sclk),
    .cs       (cs),
    .ack      (ack),
    .rx_byte  (rx_byte)
  );

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (start) state_d = WRITE;
      WRITE: begin
        go = !launched;
        if (ack) state_d = GAP_W;
      end
      GAP_W: if (gap_cnt == '0) state_d = entry.verify ? READ : NEXT;
      READ: begin
        go = !launched;
        if (ack) state_d = GAP_R;
      end
      GAP_R: if (gap_cnt == '0) state_d = CHECK;
      CHECK: begin
        if (match)                  state_d = NEXT;
        else if (retry < RETRY_LIM) state_d = WRITE;
        else                        state_d = ERROR;
      end
      NEXT:    state_d = (index == LAST_IDX) ? DONE : WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      index    <= '0;
      retry    <= '0;
      launched <= 1'b0;
      gap_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      state_q <= state_d;
      if (ack)     launched <= 1'b0;
      else if (go) launched <= 1'b1;
      if (ack)                gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 9'd1;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            done  <= 1'b0;
            err   <= 1'b0;
            index <= '0;
            retry <= '0;
          end
        end
        CHECK: begin
          if (!match) begin
            if (retry < RETRY_LIM) begin
              retry <= retry + 8'd1;
            end else begin
              err_addr <= entry.addr;
              err      <= 1'b1;
            end
          end
        end
        NEXT: begin
          retry <= '0;
          if (index == LAST_IDX) done  <= 1'b1;
          else                   index <= index + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc_cfg_sequencer.sv
// Randomized bench for ltc_cfg_sequencer: an echoing ADC model with injectable
// readback errors, and a table-driven model of the expected frame sequence.
module tb_ltc_cfg_sequencer;

  localparam int D    = 2;
  localparam int NREG = 5;
  localparam int RMAX = 2;
  localparam int T    = 10;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic       sdout;
  logic       sdin;
  logic       sclk;
  logic       cs;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] err_addr;

  int n_chk;
  int n_fail;

  logic [6:0] t_addr [NREG];
  logic [7:0] t_data [NREG];
  logic       t_ver  [NREG];

  logic [7:0] adc_mem  [128];
  int         bad_left [128];
  logic [7:0] bad_val  [128];

  logic [15:0] frames [$];
  logic [15:0] exp_q  [$];
  logic        exp_err;
  logic [6:0]  exp_err_addr;

  logic [15:0] fr;
  logic [7:0]  resp;
  int          bitcnt;
  int          cs_falls;
  int          cs_rises;
  time         t_csfall;
  time         t_csrise;
  time         t_rise;

  ltc_cfg_sequencer #(
    .CLK_DIV  (D),
    .NUM_REGS (NREG),
    .RETRY_MAX(RMAX)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .sdout    (sdout),
    .sdin     (sdin),
    .sclk     (sclk),
    .cs       (cs),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_addr (err_addr)
  );

  initial begin
    sys_clk = 1'b0;
    forever #(T/2) sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ADC model: mode 0 slave, echoes written registers unless a bad readback is armed.
  always @(negedge cs) begin
    if (cs_rises > 0)
      check("cs_high_gap", 32'(($time - t_csrise) >= time'(2 * D * T)), 32'd1);
    bitcnt   = 0;
    fr       = '0;
    t_csfall = $time;
    cs_falls++;
  end

  always @(posedge sclk) begin
    if (cs === 1'b0) begin
      fr = {fr[14:0], sdin};
      bitcnt++;
      if (bitcnt == 1) check("sclk_lead", 32'($time - t_csfall), 32'(D * T));
      else             check("sclk_period", 32'($time - t_rise), 32'(2 * D * T));
      t_rise = $time;
    end
  end

  always @(negedge sclk) begin
    if (cs === 1'b0 && bitcnt >= 8 && bitcnt < 16) begin
      if (bitcnt == 8) begin
        resp = 8'h00;
        if (fr[7]) begin
          if (bad_left[fr[6:0]] > 0) begin
            bad_left[fr[6:0]]--;
            resp = bad_val[fr[6:0]];
          end else begin
            resp = adc_mem[fr[6:0]];
          end
        end
      end
      sdout = resp[15 - bitcnt];
    end
  end

  always @(posedge cs) begin
    cs_rises++;
    t_csrise = $time;
    if (bitcnt == 16) begin
      check("cs_low_cycles", 32'(($time - t_csfall) / T), 32'(D + 32 * D + D));
      frames.push_back(fr);
      if (!fr[15]) adc_mem[fr[14:8]] = fr[7:0];
    end
    bitcnt = 0;
  end

  // Expected frame list for one pass, from the table and the armed bad readbacks.
  task automatic build_expect();
    int bl [128];
    bit ok;
    bl = bad_left;
    exp_q.delete();
    exp_err      = 1'b0;
    exp_err_addr = '0;
    for (int i = 0; i < NREG && !exp_err; i++) begin
      ok = 1'b0;
      for (int a = 0; a <= RMAX && !ok; a++) begin
        exp_q.push_back({1'b0, t_addr[i], t_data[i]});
        if (!t_ver[i]) begin
          ok = 1'b1;
        end else begin
          exp_q.push_back({1'b1, t_addr[i], 8'h00});
          if (bl[t_addr[i]] == 0) begin
            ok = 1'b1;
          end else begin
            bl[t_addr[i]]--;
            if (a == RMAX) begin
              exp_err      = 1'b1;
              exp_err_addr = t_addr[i];
            end
          end
        end
      end
    end
  endtask

  task automatic run_pass(input bit poke);
    int cyc;
    int poke_at;
    int n;
    build_expect();
    frames.delete();
    repeat ($urandom_range(2, 12)) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    check("err_cleared", 32'(err), 32'd0);
    poke_at = poke ? int'($urandom_range(5, 300)) : -1;
    cyc = 0;
    while (busy && cyc < 20000) begin
      start = (cyc == poke_at);
      @(negedge sys_clk);
      cyc++;
    end
    start = 1'b0;
    check("pass_timeout", 32'(busy), 32'd0);
    check("frame_count", 32'(frames.size()), 32'(exp_q.size()));
    n = (frames.size() < exp_q.size()) ? frames.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("frame[%0d]", i), 32'(frames[i]), 32'(exp_q[i]));
    check("done", 32'(done), 32'(!exp_err));
    check("err", 32'(err), 32'(exp_err));
    if (exp_err) check("err_addr", 32'(err_addr), 32'(exp_err_addr));
  endtask

  task automatic randomize_bad();
    int r;
    for (int i = 1; i < NREG; i++) begin
      r = int'($urandom_range(0, 9));
      bad_left[t_addr[i]] = (r < 6) ? 0 : r - 5;
      bad_val[t_addr[i]]  = 8'($urandom_range(0, 255));
      if (bad_val[t_addr[i]] == t_data[i]) bad_val[t_addr[i]] = t_data[i] ^ 8'h01;
    end
  endtask

  initial begin
    int cyc;
    int falls0;
    t_addr = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04};
    t_data = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h01};
    t_ver  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 128; i++) begin
      adc_mem[i]  = '0;
      bad_left[i] = 0;
      bad_val[i]  = '0;
    end
    n_chk = 0; n_fail = 0; bitcnt = 0; cs_falls = 0; cs_rises = 0;
    t_csfall = 0; t_csrise = 0; t_rise = 0;
    fr = '0; resp = '0;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    sdout     = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_sdin", 32'(sdin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_addr", 32'(err_addr), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // clean pass with a start pulse injected while busy
    run_pass(1'b1);
    check("first_frame", (frames.size() > 0) ? 32'(frames[0]) : 32'hdead, 32'h0080);

    // single transient mismatch on 0x02, restarted from DONE
    bad_left[2] = 1; bad_val[2] = 8'h5a;
    run_pass(1'b0);

    // 0x03 always reads 0xFF: retries exhausted
    bad_left[3] = 1000; bad_val[3] = 8'hff;
    run_pass(1'b0);
    bad_left[3] = 0;

    for (int p = 0; p < 8; p++) begin
      randomize_bad();
      run_pass(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 128; i++) bad_left[i] = 0;

    // reset in the middle of bit 8 of the second frame
    frames.delete();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    cyc = 0;
    while (!(frames.size() == 1 && bitcnt == 8 && sclk === 1'b1) && cyc < 5000) begin
      @(negedge sys_clk);
      cyc++;
    end
    check("reach_bit8", 32'(cyc < 5000), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_cs", 32'(cs), 32'd1);
    check("async_rst_sclk", 32'(sclk), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    falls0 = cs_falls;
    repeat (60) @(negedge sys_clk);
    check("post_rst_no_frame", 32'(cs_falls - falls0), 32'd0);
    check("post_rst_cs", 32'(cs), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    run_pass(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
